// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for a single-port RAM shared between
// instruction fetch (port 0, read-only) and the load/store unit (port 1).
module ram_arbiter #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_ack,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_rdEn,
  output logic              ram_wrEn,
  inout  wire  [DWIDTH-1:0] ram_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              pick_c;
  logic              we_c;

  // On a tie the port that did not win last time is granted.
  assign pick_c = (if_req && d_req) ? ~last_grant_q : d_req;
  assign we_c   = pick_c & d_we;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    wdata_d      = wdata_q;
    ram_addr_d   = ram_addr_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (if_req || d_req) begin
          gnt_d        = pick_c;
          last_grant_d = pick_c;
          wdata_d      = pick_c ? d_wdata : wdata_q;
          ram_addr_d   = pick_c ? d_addr : if_addr;
          rd_en_d      = ~we_c;
          wr_en_d      = we_c;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // The RAM returns read data during ACCESS; capture it at the closing edge.
        if (!wr_en_q) begin
          if (gnt_q) d_rdata_d  = ram_data;
          else       if_rdata_d = ram_data;
        end
        if_ack_d = ~gnt_q;
        d_ack_d  = gnt_q;
        busy_d   = 1'b1;
        state_d  = ACK;
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      wdata_q      <= '0;
      ram_addr_q   <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      wdata_q      <= wdata_d;
      ram_addr_q   <= ram_addr_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  // Bus is driven only while a registered write strobe is active.
  assign ram_data = wr_en_q ? wdata_q : {DWIDTH{1'bz}};

  assign if_ack   = if_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_ack    = d_ack_q;
  assign d_rdata  = d_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_rdEn = rd_en_q;
  assign ram_wrEn = wr_en_q;
  assign busy     = busy_q;

endmodule
